// File: rtl/fft_pkg.sv
// Shared constants, FSM state type and index helpers for the FFT frame blocks.
package fft_pkg;

  localparam int N_PTS   = 128;
  localparam int LOG2N   = 7;
  localparam int DW      = 34;
  localparam int FRAME_W = N_PTS * DW;

  typedef enum logic {
    IDLE,
    STREAM
  } state_e;

  // Reverse the low 'width' bits of idx; bits above width come back as zero.
  function automatic logic [31:0] bit_rev(input logic [31:0] idx, input int width);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < width) r[width-1-i] = idx[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_sample_mux.sv
// Combinational N_PTS:1 sample select from a flat frame buffer, optionally
// addressing the buffer through the bit-reversed output position.
module fft_sample_mux #(
  parameter int N_PTS   = fft_pkg::N_PTS,
  parameter int LOG2N   = fft_pkg::LOG2N,
  parameter int DW      = fft_pkg::DW,
  parameter int BIT_REV = 0
) (
  input  logic [N_PTS*DW-1:0] frame_buf,
  input  logic [LOG2N-1:0]    idx,
  output logic [DW-1:0]       sample
);
  import fft_pkg::*;

  logic [31:0]      rev_full;
  logic [LOG2N-1:0] sel;

  assign rev_full = bit_rev({{(32-LOG2N){1'b0}}, idx}, LOG2N);
  assign sel      = (BIT_REV != 0) ? rev_full[LOG2N-1:0] : idx;
  assign sample   = frame_buf[sel*DW +: DW];

endmodule

// File: rtl/fft_frame_serializer.sv
// Captures a flat FFT output frame on a valid/ready handshake and streams it
// out one sample per beat with last/index sidebands.
module fft_frame_serializer #(
  parameter int N_PTS   = fft_pkg::N_PTS,
  parameter int LOG2N   = fft_pkg::LOG2N,
  parameter int DW      = fft_pkg::DW,
  parameter int BIT_REV = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_PTS*DW-1:0] frame_in,
  input  logic                frame_valid,
  output logic                frame_ready,
  output logic [DW-1:0]       s_data,
  output logic                s_valid,
  input  logic                s_ready,
  output logic                s_last,
  output logic [LOG2N-1:0]    s_index,
  output logic                busy
);
  import fft_pkg::*;

  state_e              state, state_nxt;
  logic [LOG2N-1:0]    idx, idx_nxt;
  logic [N_PTS*DW-1:0] frame_buf;
  logic [DW-1:0]       mux_data;
  logic                beat;
  logic                last_pos;
  logic                capture;

  assign last_pos = (idx == LOG2N'(N_PTS - 1));
  assign s_valid  = (state == STREAM);
  assign beat     = s_valid & s_ready;

  // Ready on the last accepted beat lets the next frame follow with no bubble;
  // this makes frame_ready combinational on s_ready.
  assign frame_ready = rst_n & ((state == IDLE) | (beat & last_pos));
  assign capture     = frame_valid & frame_ready;

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    case (state)
      IDLE: begin
        if (capture) begin
          state_nxt = STREAM;
          idx_nxt   = '0;
        end
      end
      STREAM: begin
        if (beat) begin
          if (last_pos) begin
            idx_nxt   = '0;
            state_nxt = capture ? STREAM : IDLE;
          end else begin
            idx_nxt = idx + 1'b1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        idx_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  // Data buffer carries no reset; capture is already gated off by rst_n.
  always_ff @(posedge clk) begin
    if (capture) frame_buf <= frame_in;
  end

  fft_sample_mux #(
    .N_PTS  (N_PTS),
    .LOG2N  (LOG2N),
    .DW     (DW),
    .BIT_REV(BIT_REV)
  ) u_mux (
    .frame_buf(frame_buf),
    .idx      (idx),
    .sample   (mux_data)
  );

  assign s_data  = s_valid ? mux_data : '0;
  assign s_last  = s_valid & last_pos;
  assign s_index = idx;
  assign busy    = s_valid;

endmodule

// File: tb/tb_fft_frame_serializer.sv
// Randomized bench for fft_frame_serializer: natural-order and bit-reversed
// instances share stimulus and are checked against a frame-level model.
module tb_fft_frame_serializer;
  import fft_pkg::*;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [FRAME_W-1:0] frame_in;
  logic               frame_valid;
  logic               s_ready;

  logic             fr0, sv0, sl0, busy0;
  logic             fr1, sv1, sl1, busy1;
  logic [DW-1:0]    sd0, sd1;
  logic [LOG2N-1:0] si0, si1;

  int n_chk = 0;
  int n_bad = 0;

  logic [DW-1:0] fdrv[N_PTS];
  logic [DW-1:0] mbuf[N_PTS];
  bit            m_stream;
  int            m_pos;
  bit            m_captured;

  always #5 clk = ~clk;

  fft_frame_serializer #(.BIT_REV(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .frame_in(frame_in), .frame_valid(frame_valid),
    .frame_ready(fr0), .s_data(sd0), .s_valid(sv0), .s_ready(s_ready),
    .s_last(sl0), .s_index(si0), .busy(busy0)
  );

  fft_frame_serializer #(.BIT_REV(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .frame_in(frame_in), .frame_valid(frame_valid),
    .frame_ready(fr1), .s_data(sd1), .s_valid(sv1), .s_ready(s_ready),
    .s_last(sl1), .s_index(si1), .busy(busy1)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int rev(input int j);
    int r = 0;
    for (int b = 0; b < LOG2N; b++)
      if ((j & (1 << b)) != 0) r |= 1 << (LOG2N - 1 - b);
    return r;
  endfunction

  // mode 0: sample k = base + k; mode 1: random samples
  task automatic load_frame(input int mode, input int base);
    logic [63:0] t;
    for (int k = 0; k < N_PTS; k++) begin
      if (mode == 0) t = 64'(base + k);
      else           t = {$urandom, $urandom};
      fdrv[k] = t[DW-1:0];
      frame_in[k*DW +: DW] = fdrv[k];
    end
  endtask

  task automatic check_outputs();
    logic          exp_fr, exp_last;
    logic [DW-1:0] exp_d0, exp_d1;
    exp_fr   = rst_n && (!m_stream || (s_ready && m_pos == N_PTS - 1));
    exp_last = m_stream && (m_pos == N_PTS - 1);
    exp_d0   = m_stream ? mbuf[m_pos] : '0;
    exp_d1   = m_stream ? mbuf[rev(m_pos)] : '0;
    chk("frame_ready0", 64'(fr0), 64'(exp_fr));
    chk("frame_ready1", 64'(fr1), 64'(exp_fr));
    chk("s_valid0", 64'(sv0), 64'(m_stream));
    chk("s_valid1", 64'(sv1), 64'(m_stream));
    chk("s_data_nat", 64'(sd0), 64'(exp_d0));
    chk("s_data_rev", 64'(sd1), 64'(exp_d1));
    chk("s_last0", 64'(sl0), 64'(exp_last));
    chk("s_last1", 64'(sl1), 64'(exp_last));
    chk("s_index0", 64'(si0), 64'(m_pos));
    chk("s_index1", 64'(si1), 64'(m_pos));
    chk("busy0", 64'(busy0), 64'(m_stream));
    chk("busy1", 64'(busy1), 64'(m_stream));
  endtask

  task automatic model_update();
    m_captured = 1'b0;
    if (!rst_n) begin
      m_stream = 1'b0;
      m_pos    = 0;
    end else if (!m_stream) begin
      if (frame_valid) begin
        for (int k = 0; k < N_PTS; k++) mbuf[k] = fdrv[k];
        m_stream   = 1'b1;
        m_pos      = 0;
        m_captured = 1'b1;
      end
    end else if (s_ready) begin
      if (m_pos == N_PTS - 1) begin
        m_pos = 0;
        if (frame_valid) begin
          for (int k = 0; k < N_PTS; k++) mbuf[k] = fdrv[k];
          m_captured = 1'b1;
        end else begin
          m_stream = 1'b0;
        end
      end else begin
        m_pos++;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check_outputs();
    model_update();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit held, tog, done;

    rst_n       = 1'b0;
    frame_valid = 1'b1;
    s_ready     = 1'b1;
    load_frame(1, 0);
    m_stream    = 1'b0;
    m_pos       = 0;
    @(posedge clk);
    #1;

    // reset held with a frame offered: nothing captured, all outputs quiet
    repeat (3) tick();
    rst_n       = 1'b1;
    frame_valid = 1'b0;
    tick();

    // single frame, natural and bit-reversed order; frame_in scrambled after capture
    load_frame(0, 0);
    frame_valid = 1'b1;
    tick();
    frame_valid = 1'b0;
    load_frame(1, 0);
    repeat (132) tick();

    // backpressure: alternating ready, plus a 5-cycle stall at index 63
    load_frame(0, 0);
    frame_valid = 1'b1;
    tick();
    frame_valid = 1'b0;
    held = 1'b0;
    tog  = 1'b1;
    for (int c = 0; c < 300; c++) begin
      if (m_stream && m_pos == 63 && !held) begin
        s_ready = 1'b0;
        repeat (5) tick();
        held = 1'b1;
      end
      s_ready = tog;
      tog     = ~tog;
      tick();
    end
    s_ready = 1'b1;
    repeat (3) tick();

    // back-to-back: frame B waits while frame A streams
    load_frame(0, 0);
    frame_valid = 1'b1;
    tick();
    load_frame(0, 1000);
    for (int c = 0; c < 300; c++) begin
      tick();
      if (m_captured) frame_valid = 1'b0;
    end

    // reset for one cycle in the middle of a frame
    load_frame(0, 0);
    frame_valid = 1'b1;
    tick();
    frame_valid = 1'b0;
    done = 1'b0;
    for (int c = 0; c < 60; c++) begin
      if (m_stream && m_pos == 40 && !done) begin
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        done  = 1'b1;
      end else begin
        tick();
      end
    end
    load_frame(0, 0);
    frame_valid = 1'b1;
    tick();
    frame_valid = 1'b0;
    repeat (135) tick();

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      frame_valid = ($urandom_range(0, 3) == 0);
      s_ready     = ($urandom_range(0, 3) != 0);
      rst_n       = ($urandom_range(0, 499) != 0);
      if ($urandom_range(0, 15) == 0) load_frame(1, 0);
      tick();
    end
    rst_n = 1'b1;

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/fft_frame_serializer.md
Name: fft_frame_serializer

Overview:
- Reader side of the parallel 128-point FFT result bus.
- Captures one complete flat FFT output frame (128 samples × 34 bits = 4352 bits) into a local buffer on a valid/ready handshake.
- Streams the frame out one sample per beat, with valid/ready, last and index sidebands, for downstream logging or post-processing.
- Optionally reorders bit-reversed FFT output into natural order.

Parameters:
- N_PTS, 128: samples per frame.
- LOG2N, 7: index width; must equal log2(N_PTS).
- DW, 34: sample width. The sample is an opaque complex word and is passed bit-exact.
- BIT_REV, 0: 0 = emit buffer order; 1 = output position j reads buffer element bitrev_LOG2N(j).

Ports:
- clk  in  1  single clock; all state on its rising edge.
- rst_n  in  1  synchronous active-low reset.
- frame_in  in  N_PTS*DW  flat frame; sample k at frame_in[k*DW +: DW] (sample 0 at LSBs).
- frame_valid  in  1  frame_in holds a complete frame.
- frame_ready  out  1  block will capture frame_in this cycle.
- s_data  out  DW  current output sample.
- s_valid  out  1  s_data valid.
- s_ready  in  1  downstream accepts the beat.
- s_last  out  1  high on the final beat of a frame (position N_PTS-1).
- s_index  out  LOG2N  natural output position j of the current beat.
- busy  out  1  frame held or streaming (state STREAM).

Behaviour:
- Clock and reset: one clock, reset synchronous and active-low.
- Reset (rst_n low at an edge):
  - state = IDLE, idx = 0.
  - s_valid = 0, s_last = 0, s_index = 0, busy = 0.
  - s_data = 0 whenever s_valid = 0.
  - frame_ready is forced 0 while rst_n is low.
  - The frame buffer is not reset.
- States: IDLE, STREAM.
- IDLE:
  - frame_ready = 1.
  - On frame_valid & frame_ready: buffer <= frame_in, idx <= 0, go to STREAM.
- STREAM:
  - s_valid = 1; s_data = buffer[map(idx)]; s_index = idx.
  - s_last = (idx == N_PTS-1).
  - map(idx) = idx if BIT_REV = 0, else bitrev(idx).
- Latency: the first beat (idx 0) is presented the cycle after frame capture.
- Beat transfer: occurs when s_valid & s_ready.
  - Not last: idx <= idx+1.
  - Last beat: idx <= 0. If frame_valid is also high, capture the new frame and stay in STREAM (no bubble); otherwise go to IDLE.
- frame_ready = rst_n & (IDLE | (s_valid & s_ready & s_last)). This is a combinational path from s_ready to frame_ready, and it is intended.
- Backpressure: while s_ready = 0, s_data, s_index and s_last hold stable. No sample is dropped or duplicated.
- frame_in is sampled only on the capture edge. Later changes to frame_in do not affect the frame in flight.
- Reset mid-stream: the frame is discarded and s_valid = 0 after the reset edge. No s_last is emitted for the partial frame. The next frame starts at idx 0.
- Wrap: idx never exceeds N_PTS-1. There is no other boundary condition.
- Throughput: one sample per cycle sustained. Back-to-back frames take N_PTS cycles each.

Decomposition:
- Shared package fft_pkg:
  - constants N_PTS = 128, LOG2N = 7, DW = 34, FRAME_W = N_PTS*DW.
  - state enum {IDLE, STREAM}.
  - function bit_rev(idx, LOG2N).
  - The combinational FFT top and future frame blocks use the same constants.
- One sub-module, fft_sample_mux: purely combinational N_PTS:1 DW-bit select of the buffer by map(idx), with optional bit reversal.
- The FSM, counter and buffer stay in the top.

Test Plan:
- Reset:
  - Stimulus: rst_n low for 3 cycles with frame_valid = 1.
  - Response: frame_ready = 0, s_valid = 0, s_data = 0 throughout; no capture; frame_ready = 1 the first cycle after release.
- Single frame, natural order (BIT_REV = 0):
  - Stimulus: sample k = k, s_ready = 1.
  - Response: frame_ready = 0 the cycle after capture; s_data = 0..127 with s_index = 0..127 on 128 consecutive cycles; s_last only on value 127; busy drops after.
- Backpressure:
  - Stimulus: s_ready toggled 1,0,1,0…, plus held low 5 cycles when s_index = 63.
  - Response: s_data holds 63 with s_last = 0; exactly 128 beats 0..127, no gaps, no repeats.
- Bit-reverse (BIT_REV = 1):
  - Stimulus: sample k = k.
  - Response: s_data sequence 0,64,32,96,16,80,…,127; s_index 0..127; s_last with data 127.
- Back-to-back:
  - Stimulus: frame B (sample k = 1000+k) valid while frame A's last beat is accepted.
  - Response: frame_ready = 1 that cycle; B sample 0 on the next cycle; 256 beats in 256 cycles.
- Reset mid-stream:
  - Stimulus: rst_n low one cycle at s_index = 40.
  - Response: s_valid = 0 next cycle; no s_last; the next frame streams from value 0.
